ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning the CLK100MHz frequency in Hz used to derive all timing.
REQ-002 SHALL have parameter INHIBIT_US, default 120, meaning the clock-inhibit time in microseconds before the start bit.
REQ-003 SHALL have port CLK100MHz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports tx_valid (input, 1), tx_data (input, 8) and tx_ready (output, 1): a byte is accepted on a cycle where tx_valid and tx_ready are both 1.
REQ-006 SHALL have ports ps2_clk_i and ps2_data_i, inputs, 1 bit each: raw PS/2 line levels, asynchronous.
REQ-007 SHALL have ports ps2_clk_oe and ps2_data_oe, outputs, 1 bit each: 1 drives the line low; 0 releases it to the pull-up.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer ends.
REQ-009 SHALL have ports nack and tout, outputs, 1 bit each: status flags valid while done=1.
REQ-010 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.

Function
REQ-011 SHALL pass ps2_clk_i and ps2_data_i through a 2-flop synchronizer and detect a falling edge when synced clock goes 1->0.
REQ-012 SHALL use states IDLE, INHIBIT, REQ, BITS, ACK, WAITIDLE and FIN.
REQ-013 In IDLE, tx_ready SHALL be 1; on acceptance it SHALL latch tx_data and odd parity (~^tx_data), then enter INHIBIT.
REQ-014 INHIBIT SHALL hold ps2_clk_oe=1 for INHIBIT_CYC = CLK_HZ/1000000*INHIBIT_US cycles.
REQ-015 INHIBIT SHALL assert ps2_data_oe=1 during its final cycle, giving the start bit.
REQ-016 REQ SHALL release the clock (ps2_clk_oe=0), keep ps2_data_oe=1 and clear the 4-bit edge counter.
REQ-017 On each synced falling edge, the edge counter SHALL increment and the host SHALL update data within 2 cycles: edges 1-8 drive data bits 0-7 (LSB first), edge 9 drives parity, edge 10 releases data (stop bit).
REQ-018 Throughout, ps2_data_oe SHALL equal the inverse of the bit being sent.
REQ-019 Edge 10 SHALL move the state to ACK.
REQ-020 At the next falling edge (edge 11) in ACK, the host SHALL sample synced data: 0 is an acknowledge (nack=0), 1 sets nack=1; then the state SHALL move to WAITIDLE.
REQ-021 WAITIDLE SHALL wait until synced clock and data are both 1, then enter FIN.
REQ-022 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-023 In IDLE both oe outputs SHALL be 0; tx_valid outside IDLE SHALL be ignored (tx_ready=0).
REQ-024 Edges SHALL be counted modulo nothing: any falling edge beyond 11 before IDLE SHALL be ignored.

Reset
REQ-025 While reset_n=0 (asynchronous assert, synchronous release via the clock domain), the block SHALL hold state=IDLE and tx_ready=1.
REQ-026 While reset_n=0, the block SHALL hold busy=0, done=0, nack=0, tout=0, ps2_clk_oe=0, ps2_data_oe=0, and the synchronizer flops at 1.
REQ-027 Reset asserted mid-transfer SHALL immediately release both lines and abandon the byte with no done pulse.

Configuration
REQ-028 With macro PS2_HOST_TX_TIMEOUT_EN defined, a watchdog SHALL abort to FIN with tout=1 and both lines released if edge 1 is not seen within 15 ms of leaving INHIBIT, or edge 11 is not seen within 2 ms of edge 1.
REQ-029 With PS2_HOST_TX_TIMEOUT_EN undefined, the watchdog SHALL be absent, tout SHALL be constant 0, and the block SHALL wait indefinitely.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enumeration, the edge-index constants (EDGE_PARITY=9, EDGE_STOP=10, EDGE_ACK=11) and the timeout constants in microseconds (15000, 2000).
REQ-031 Sub-module ps2_sync SHALL implement the 2-flop synchronizers and the falling-edge detect, and is reused by the receiver.
REQ-032 Counter widths SHALL be computed with $clog2 of the largest cycle count.

Verification
REQ-033 Send 0xED to a device model that acks: after ps2_clk_oe low for 12000 cycles, the model SHALL see bits 1,0,1,1,0,1,1,1, parity 1 and stop 1, and the host SHALL report done with nack=0, tout=0.
REQ-034 Send 0x00 to a device model that does not ack: the model SHALL see parity 1, and the host SHALL report done with nack=1.
REQ-035 Timeout build, device never clocks: done with tout=1 exactly 15 ms + 1 cycle after INHIBIT ends, and both oe outputs 0.
REQ-036 Assert reset_n low at edge 5 of a transfer: both oe outputs SHALL be 0 in the same cycle, done SHALL stay 0, and tx_ready=1 after release.
REQ-037 Hold tx_valid=1 continuously with data 0xF4 then 0x55: exactly two transfers SHALL occur, the second starting only after done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, edge indices and watchdog limits.
package ps2_pkg;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_REQ      = 3'd2;
    localparam logic [2:0] ST_BITS     = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_WAITIDLE = 3'd5;
    localparam logic [2:0] ST_FIN      = 3'd6;
    localparam logic [3:0] EDGE_PARITY = 4'd9;
    localparam logic [3:0] EDGE_STOP   = 4'd10;
    localparam logic [3:0] EDGE_ACK    = 4'd11;
    localparam int TOUT_START_US = 15000;
    localparam int TOUT_BITS_US  = 2000;
    function automatic int us_to_cyc(input int clk_hz, input int us);
        return clk_hz / 1000000 * us;
    endfunction
endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: 2-flop synchronizers for the PS/2 lines plus clock falling-edge detect.
module ps2_sync (
    input  logic CLK100MHz,
    input  logic reset_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);
    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;
    always_ff @(posedge CLK100MHz or negedge reset_n) begin
        if (!reset_n) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_i};
            data_ff  <= {data_ff[0], ps2_data_i};
            clk_prev <= clk_ff[1];
        end
    end
    assign clk_s    = clk_ff[1];
    assign data_s   = data_ff[1];
    assign clk_fall = clk_prev & ~clk_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with inhibit, start, bits, parity, stop and ack.
// Define PS2_HOST_TX_TIMEOUT_EN to add the 15 ms / 2 ms watchdog that reports tout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int INHIBIT_US = 120
) (
    input  logic       CLK100MHz,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       nack,
    output logic       tout,
    output logic       busy
);
    localparam int INHIBIT_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int START_CYC = us_to_cyc(CLK_HZ, TOUT_START_US);
    localparam int BITS_CYC  = us_to_cyc(CLK_HZ, TOUT_BITS_US);
    localparam int CNT_MAX   = INHIBIT_CYC > START_CYC ? (INHIBIT_CYC > BITS_CYC ? INHIBIT_CYC : BITS_CYC)
                                                       : (START_CYC > BITS_CYC ? START_CYC : BITS_CYC);
`else
    localparam int CNT_MAX   = INHIBIT_CYC;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       edge_cnt;
    logic [3:0]       edge_next;
    logic [7:0]       data_r;
    logic             parity_r;
    logic             nack_r;
    logic             clk_s;
    logic             data_s;
    logic             clk_fall;
    logic             inhibit_last;
    logic             abort;
    logic [15:0]      frame;
    logic             bit_out;

    ps2_sync u_sync (
        .CLK100MHz  (CLK100MHz),
        .reset_n    (reset_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fall   (clk_fall)
    );

    assign edge_next    = edge_cnt + 4'd1;
    assign inhibit_last = (state == ST_INHIBIT) && (cnt == CNT_W'(INHIBIT_CYC - 1));
    // frame[0] is the start bit; everything past the data byte reads as released (1)
    assign frame        = {7'h7f, data_r, 1'b0};
    assign bit_out      = (edge_cnt == EDGE_PARITY) ? parity_r : frame[edge_cnt];

    assign tx_ready    = (state == ST_IDLE);
    assign busy        = ~tx_ready;
    assign done        = (state == ST_FIN);
    assign nack        = nack_r;
    assign ps2_clk_oe  = (state == ST_INHIBIT);
    assign ps2_data_oe = inhibit_last || (((state == ST_REQ) || (state == ST_BITS)) && ~bit_out);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    logic tout_r;
    // before edge 1 the budget is the start window, afterwards the whole-frame window
    assign abort = ((state == ST_BITS) || (state == ST_ACK)) &&
                   (cnt == ((edge_cnt == 4'd0) ? CNT_W'(START_CYC - 1) : CNT_W'(BITS_CYC - 1)));
    assign tout  = tout_r;
    always_ff @(posedge CLK100MHz or negedge reset_n) begin
        if (!reset_n)
            tout_r <= 1'b0;
        else if (tx_ready && tx_valid)
            tout_r <= 1'b0;
        else if (abort)
            tout_r <= 1'b1;
    end
`else
    assign abort = 1'b0;
    assign tout  = 1'b0;
`endif

    always_ff @(posedge CLK100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            data_r   <= '0;
            parity_r <= 1'b0;
            nack_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (tx_valid) begin
                    data_r   <= tx_data;
                    parity_r <= ~^tx_data;
                    nack_r   <= 1'b0;
                    cnt      <= '0;
                    edge_cnt <= '0;
                    state    <= ST_INHIBIT;
                end
                ST_INHIBIT: begin
                    cnt <= cnt + 1'b1;
                    if (inhibit_last) state <= ST_REQ;
                end
                ST_REQ: begin
                    cnt      <= '0;
                    edge_cnt <= '0;
                    state    <= ST_BITS;
                end
                ST_BITS, ST_ACK: begin
                    cnt <= cnt + 1'b1;
                    if (abort)
                        state <= ST_FIN;
                    else if (clk_fall) begin
                        edge_cnt <= edge_next;
                        if (edge_cnt == 4'd0) cnt <= '0;
                        if (edge_next == EDGE_ACK) begin
                            nack_r <= data_s;
                            state  <= ST_WAITIDLE;
                        end else if (edge_next == EDGE_STOP)
                            state <= ST_ACK;
                    end
                end
                ST_WAITIDLE: if (clk_s && data_s) state <= ST_FIN;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
